// File: rtl/ffwr_ctrl_pkg.sv
// Shared dual-clock FIFO definitions: depth, Gray/binary pointer conversion
// and the overflow counter width, common to the wrclk and rdclk controllers.
package ffwr_ctrl_pkg;

    localparam int PTR_MAXW = 32;
    localparam int OVFCNT_W = 8;

    function automatic int depth_of(input int addrbit);
        return 1 << addrbit;
    endfunction

    // Callers zero-extend narrower pointers and truncate the result.
    function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g);
        logic [PTR_MAXW-1:0] b;
        b[PTR_MAXW-1] = g[PTR_MAXW-1];
        for (int i = PTR_MAXW-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ffwr_ctrl_sync.sv
// Parameterized-width 2-flop synchronizer, async active-low reset to 0.
// Latency: 2 wrclk edges; no backpressure.
module ffsync2 #(
    parameter int W = 1
) (
    input  logic         wrclk,
    input  logic         rst_,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q1;

    always_ff @(posedge wrclk or negedge rst_) begin
        if (!rst_) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/ffwr_ctrl.sv
// Write-side controller of a dual-clock FIFO: pointer, full/afull/level, overflow count.
// Latency: write accepted at edge N visible after edge N; read pointer seen 3 edges later.
// Backpressure: wren is suppressed while full or flushing; dropped requests are counted.
module ffwr_ctrl
    import ffwr_ctrl_pkg::*;
#(
    parameter int ADDRBIT  = 4,
    parameter int AFULL_TH = 12
) (
    input  logic                  wrclk,
    input  logic                  rst_,
    input  logic                  wrreq,
    input  logic [ADDRBIT:0]      rdptr_gray,
    input  logic                  flush,
    input  logic                  ovfclr,
    output logic                  wren,
    output logic [ADDRBIT-1:0]    wraddr,
    output logic [ADDRBIT:0]      wrptr_gray,
    output logic                  full,
    output logic                  afull,
    output logic [ADDRBIT:0]      wrlevel,
    output logic                  ovf,
    output logic [OVFCNT_W-1:0]   ovfcnt
);

    localparam int PW    = ADDRBIT + 1;
    localparam int DEPTH = depth_of(ADDRBIT);
    localparam logic [OVFCNT_W-1:0] OVF_MAX = '1;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] rq2;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] lvl_next;
    logic          drop;

    ffsync2 #(.W(PW)) u_rdptr_sync (
        .wrclk (wrclk),
        .rst_  (rst_),
        .d     (rdptr_gray),
        .q     (rq2)
    );

    assign rbin_s    = PW'(gray2bin(PTR_MAXW'(rq2)));
    assign wren      = wrreq & ~full & ~flush;
    assign drop      = wrreq & full & ~flush;
    assign wbin_next = wbin + PW'(wren);
    assign lvl_next  = wbin_next - rbin_s;
    assign wraddr    = wbin[ADDRBIT-1:0];

    // A corrupt (too-far-ahead) read pointer yields lvl_next > DEPTH, which keeps full set.
    always_ff @(posedge wrclk or negedge rst_) begin
        if (!rst_) begin
            wbin       <= '0;
            wrptr_gray <= '0;
            wrlevel    <= '0;
            full       <= 1'b0;
            afull      <= 1'b0;
            ovf        <= 1'b0;
        end else if (flush) begin
            wbin       <= rbin_s;
            wrptr_gray <= rq2;
            wrlevel    <= '0;
            full       <= 1'b0;
            afull      <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            wbin       <= wbin_next;
            wrptr_gray <= PW'(bin2gray(PTR_MAXW'(wbin_next)));
            wrlevel    <= lvl_next;
            full       <= int'(lvl_next) >= DEPTH;
            afull      <= int'(lvl_next) >= AFULL_TH;
            ovf        <= drop;
        end
    end

    // Clear is applied before the same-cycle drop is counted.
    always_ff @(posedge wrclk or negedge rst_) begin
        if (!rst_) begin
            ovfcnt <= '0;
        end else if (ovfclr) begin
            ovfcnt <= OVFCNT_W'(drop);
        end else if (drop && ovfcnt != OVF_MAX) begin
            ovfcnt <= ovfcnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ffwr_ctrl.sv
// Directed self-checking bench for ffwr_ctrl (ADDRBIT=4, AFULL_TH=12).
module tb_ffwr_ctrl;

    logic       wrclk = 1'b0;
    logic       rst_;
    logic       wrreq;
    logic [4:0] rdptr_gray;
    logic       flush;
    logic       ovfclr;
    logic       wren;
    logic [3:0] wraddr;
    logic [4:0] wrptr_gray;
    logic       full;
    logic       afull;
    logic [4:0] wrlevel;
    logic       ovf;
    logic [7:0] ovfcnt;

    int nvec = 0;
    int nerr = 0;

    ffwr_ctrl #(.ADDRBIT(4), .AFULL_TH(12)) dut (
        .wrclk      (wrclk),
        .rst_       (rst_),
        .wrreq      (wrreq),
        .rdptr_gray (rdptr_gray),
        .flush      (flush),
        .ovfclr     (ovfclr),
        .wren       (wren),
        .wraddr     (wraddr),
        .wrptr_gray (wrptr_gray),
        .full       (full),
        .afull      (afull),
        .wrlevel    (wrlevel),
        .ovf        (ovf),
        .ovfcnt     (ovfcnt)
    );

    always #5 wrclk = ~wrclk;

    function automatic logic [4:0] g5(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wrclk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".wraddr"},     32'(wraddr),     0);
        chk({tag, ".wrptr_gray"}, 32'(wrptr_gray), 0);
        chk({tag, ".full"},       32'(full),       0);
        chk({tag, ".afull"},      32'(afull),      0);
        chk({tag, ".wrlevel"},    32'(wrlevel),    0);
        chk({tag, ".ovf"},        32'(ovf),        0);
        chk({tag, ".ovfcnt"},     32'(ovfcnt),     0);
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        #3;
        tick();
        rst_ = 1'b1;
    endtask

    initial begin
        int wt;
        int wraps;
        logic [4:0] prevg;

        rst_ = 1'b0; wrreq = 1'b0; rdptr_gray = '0; flush = 1'b0; ovfclr = 1'b0;
        #2;
        chk_reset_outputs("por");
        tick();
        rst_ = 1'b1;
        wrreq = 1'b1;
        #1;
        chk("por.wren_follows", 32'(wren), 1);

        // Fill from empty
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("fill%0d.wrlevel", i), 32'(wrlevel), 32'(i));
            chk($sformatf("fill%0d.afull", i),   32'(afull), 32'(i >= 12));
            chk($sformatf("fill%0d.full", i),    32'(full),  32'(i == 16));
        end
        chk("fill.wren_blocked", 32'(wren), 0);
        tick();
        wrreq = 1'b0;
        chk("drop.ovf", 32'(ovf), 1);
        chk("drop.ovfcnt", 32'(ovfcnt), 1);
        chk("drop.wrlevel", 32'(wrlevel), 16);
        tick();
        chk("drop.ovf_pulse_end", 32'(ovf), 0);

        // Release: reader advances to 4
        rdptr_gray = g5(5'd4);
        tick();
        tick();
        chk("rel.full_held_2edges", 32'(full), 1);
        tick();
        chk("rel.full", 32'(full), 0);
        chk("rel.wrlevel", 32'(wrlevel), 12);
        chk("rel.afull", 32'(afull), 1);

        // Asynchronous reset mid-stream
        wrreq = 1'b1;
        tick();
        tick();
        #2;
        rst_ = 1'b0;
        rdptr_gray = '0;
        #1;
        chk_reset_outputs("arst");
        tick();
        tick();
        rst_ = 1'b1;
        #1;
        chk("arst.first_wraddr", 32'(wraddr), 0);
        chk("arst.first_wren", 32'(wren), 1);

        // Flush with wrreq: build wbin=9, rbin_s=5
        for (int i = 0; i < 9; i++) tick();
        wrreq = 1'b0;
        rdptr_gray = 5'd7;
        tick(); tick(); tick();
        chk("flush.pre_level", 32'(wrlevel), 4);
        chk("flush.pre_wraddr", 32'(wraddr), 9);
        flush = 1'b1;
        wrreq = 1'b1;
        #1;
        chk("flush.wren", 32'(wren), 0);
        tick();
        flush = 1'b0;
        wrreq = 1'b0;
        chk("flush.wraddr", 32'(wraddr), 5);
        chk("flush.wrlevel", 32'(wrlevel), 0);
        chk("flush.wrptr_gray", 32'(wrptr_gray), 7);
        chk("flush.ovf", 32'(ovf), 0);
        chk("flush.full", 32'(full), 0);
        chk("flush.ovfcnt", 32'(ovfcnt), 0);

        // Wrap with reader two entries behind
        wt = 5;
        wraps = 0;
        prevg = wrptr_gray;
        wrreq = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            wt++;
            chk($sformatf("wrap%0d.wraddr", i), 32'(wraddr), 32'(wt % 16));
            chk($sformatf("wrap%0d.gray", i), 32'(wrptr_gray), 32'(g5(5'(wt))));
            chk($sformatf("wrap%0d.onebit", i), 32'($countones(wrptr_gray ^ prevg)), 1);
            chk($sformatf("wrap%0d.full", i), 32'(full), 0);
            if (wraddr == 4'd0) wraps++;
            prevg = wrptr_gray;
            rdptr_gray = g5(5'((wt >= 7) ? wt - 2 : 5));
        end
        wrreq = 1'b0;
        chk("wrap.count", 32'(wraps), 2);

        // Overflow counter saturation and clear
        rdptr_gray = '0;
        do_reset();
        wrreq = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("cnt.full", 32'(full), 1);
        for (int i = 0; i < 300; i++) tick();
        chk("cnt.sat", 32'(ovfcnt), 255);
        chk("cnt.ovf", 32'(ovf), 1);
        wrreq = 1'b0;
        ovfclr = 1'b1;
        tick();
        ovfclr = 1'b0;
        chk("clr.alone", 32'(ovfcnt), 0);
        chk("clr.ovf", 32'(ovf), 0);
        wrreq = 1'b1;
        ovfclr = 1'b1;
        tick();
        wrreq = 1'b0;
        ovfclr = 1'b0;
        chk("clr.with_drop", 32'(ovfcnt), 1);
        chk("clr.with_drop_ovf", 32'(ovf), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
